// File: rtl/erx_decoder_if.sv
// Receive-side bundle for erx_decoder: raw line and controller clears in,
// decoded byte, bit count and event pulses out.
interface erx_decoder_if;
   logic       d_line;
   logic       cnt_rst;
   logic       reset;
   logic       d_edge;
   logic       Idle;
   logic [7:0] E_Data;
   logic [3:0] count;
   logic       bit_strobe;

   modport master (
      output d_line, cnt_rst, reset,
      input  d_edge, Idle, E_Data, count, bit_strobe
   );

   modport slave (
      input  d_line, cnt_rst, reset,
      output d_edge, Idle, E_Data, count, bit_strobe
   );
endinterface

// File: rtl/erx_decoder.sv
// Manchester receive decoder: synchronizes the raw line, times mid-bit edges and
// shifts decoded bits into E_Data. Define ERX_GLITCH_FILTER_EN for a 2-of-3 line filter.
module erx_decoder (
   input  logic          clk,
   input  logic          n_rst,
   erx_decoder_if.slave  bus
);
   typedef enum logic [1:0] {LINE_IDLE, GUARD, WINDOW} state_t;

   localparam logic [3:0] GUARD_END  = 4'd5;
   localparam logic [3:0] WINDOW_END = 4'd12;

   logic       sync1_q, sync1_d, sync2_q, sync2_d;
   logic       ln, ln_prev_q, ln_prev_d;
   logic       d_edge_q, d_edge_d;
   state_t     state_q, state_d;
   logic [3:0] timer_q, timer_d;
   logic       idle_q, idle_d;
   logic [7:0] e_data_q, e_data_d;
   logic [3:0] count_q, count_d;
   logic       strobe_q, strobe_d;
   logic       decode;

`ifdef ERX_GLITCH_FILTER_EN
   logic hist1_q, hist1_d, hist2_q, hist2_d;

   always_comb begin
      hist1_d = sync2_q;
      hist2_d = hist1_q;
      ln      = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
      end else begin
         hist1_q <= hist1_d;
         hist2_q <= hist2_d;
      end
   end
`else
   always_comb ln = sync2_q;
`endif

   always_comb begin
      sync1_d   = bus.d_line;
      sync2_d   = sync1_q;
      ln_prev_d = ln;
      d_edge_d  = ln ^ ln_prev_q;
   end

   // Edges are only accepted from idle or inside the mid-bit window, so the
   // boundary transitions roughly half a bit after a decode fall into GUARD.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      decode  = 1'b0;
      case (state_q)
         LINE_IDLE: begin
            timer_d = 4'd0;
            if (d_edge_q) begin
               decode  = 1'b1;
               state_d = GUARD;
            end
         end
         GUARD: begin
            timer_d = timer_q + 4'd1;
            if (timer_q == GUARD_END) state_d = WINDOW;
         end
         WINDOW: begin
            if (d_edge_q) begin
               decode  = 1'b1;
               timer_d = 4'd0;
               state_d = GUARD;
            end else if (timer_q == WINDOW_END) begin
               timer_d = 4'd0;
               state_d = LINE_IDLE;
            end else begin
               timer_d = timer_q + 4'd1;
            end
         end
         default: begin
            timer_d = 4'd0;
            state_d = LINE_IDLE;
         end
      endcase
      idle_d = (state_d == LINE_IDLE);
   end

   // ln_prev_q holds the post-transition level while d_edge_q is high.
   always_comb begin
      e_data_d = e_data_q;
      count_d  = count_q;
      strobe_d = 1'b0;
      if (bus.reset) begin
         e_data_d = 8'h00;
         count_d  = 4'd0;
      end else if (decode) begin
         e_data_d = {e_data_q[6:0], ln_prev_q};
         count_d  = (bus.cnt_rst || count_q == 4'd8) ? 4'd1 : count_q + 4'd1;
         strobe_d = 1'b1;
      end else if (bus.cnt_rst) begin
         count_d  = 4'd0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         ln_prev_q <= 1'b0;
         d_edge_q  <= 1'b0;
         state_q   <= LINE_IDLE;
         timer_q   <= 4'd0;
         idle_q    <= 1'b1;
         e_data_q  <= 8'h00;
         count_q   <= 4'd0;
         strobe_q  <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         ln_prev_q <= ln_prev_d;
         d_edge_q  <= d_edge_d;
         state_q   <= state_d;
         timer_q   <= timer_d;
         idle_q    <= idle_d;
         e_data_q  <= e_data_d;
         count_q   <= count_d;
         strobe_q  <= strobe_d;
      end
   end

   assign bus.d_edge     = d_edge_q;
   assign bus.Idle       = idle_q;
   assign bus.E_Data     = e_data_q;
   assign bus.count      = count_q;
   assign bus.bit_strobe = strobe_q;
endmodule

// File: tb/tb_erx_decoder.sv
// Directed and randomized Manchester frames for erx_decoder, checked against a
// bit-history model of the decoded byte and count.
module tb_erx_decoder;
   logic clk;
   logic n_rst;
   erx_decoder_if bus ();

   erx_decoder dut (.clk(clk), .n_rst(n_rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef ERX_GLITCH_FILTER_EN
   localparam int LAT   = 4;
   localparam int HALF1 = 3;
`else
   localparam int LAT   = 3;
   localparam int HALF1 = 4;
`endif
   localparam int HALF2 = 8 - HALF1;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   int strobes = 0;
   int edges   = 0;
   int exp_strobes = 0;

   logic bits_q[$];
   int   nbits = 0;

   always @(posedge clk) begin
      #2;
      if (bus.bit_strobe === 1'b1) strobes++;
      if (bus.d_edge === 1'b1) edges++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_e();
      int s = bits_q.size();
      int v = 0;
      for (int k = 0; k < 8 && k < s; k++)
         if (bits_q[s-1-k]) v = v + (1 << k);
      return 8'(v);
   endfunction

   function automatic logic [3:0] exp_count();
      if (nbits == 0) return 4'd0;
      return 4'(((nbits - 1) % 8) + 1);
   endfunction

   // mode: 0 plain, 1 cnt_rst with the decode, 2 reset with the decode
   task automatic send_bit(input logic b, input int mode);
      logic pulsed = 1'b0;
      bus.d_line = ~b;
      repeat (HALF1) @(negedge clk);
      bus.d_line = b;
      for (int i = 0; i < HALF2; i++) begin
         @(negedge clk);
         bus.cnt_rst = 1'b0;
         bus.reset   = 1'b0;
         if (mode != 0 && !pulsed && bus.d_edge === 1'b1) begin
            chk("edge_latency", i + 1, LAT);
            if (mode == 1) bus.cnt_rst = 1'b1;
            else           bus.reset   = 1'b1;
            pulsed = 1'b1;
         end
      end
      if (mode != 0) chk("ctl_aligned", pulsed, 1'b1);
      if (mode == 2) begin
         bits_q.delete();
         nbits = 0;
      end else begin
         bits_q.push_back(b);
         nbits = (mode == 1) ? 1 : nbits + 1;
         exp_strobes++;
      end
      chk("E_Data_bit", bus.E_Data, exp_e());
      chk("count_bit", bus.count, exp_count());
      chk("strobes_bit", strobes, exp_strobes);
   endtask

   task automatic end_frame();
      bus.d_line = 1'b0;
      repeat (24) @(negedge clk);
      chk("Idle_after_frame", bus.Idle, 1'b1);
   endtask

   initial begin
      logic [7:0] ab;
      int e0, s0, len, r, md;
      ab = 8'hAB;
      bus.d_line  = 1'b0;
      bus.cnt_rst = 1'b0;
      bus.reset   = 1'b0;
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_Idle", bus.Idle, 1'b1);
      chk("rst_E_Data", bus.E_Data, 8'h00);
      chk("rst_count", bus.count, 4'd0);
      chk("rst_d_edge", bus.d_edge, 1'b0);
      chk("rst_strobe", bus.bit_strobe, 1'b0);
      n_rst = 1'b1;

      repeat (40) @(negedge clk);
      chk("idle40_Idle", bus.Idle, 1'b1);
      chk("idle40_E_Data", bus.E_Data, 8'h00);
      chk("idle40_count", bus.count, 4'd0);
      chk("idle40_edges", edges, 0);

      for (int i = 7; i >= 0; i--) send_bit(ab[i], 0);
      chk("AB_E_Data", bus.E_Data, 8'hAB);
      chk("AB_count", bus.count, 4'd8);
      chk("AB_Idle", bus.Idle, 1'b0);
      chk("AB_strobes", strobes, 8);
      end_frame();

      send_bit(1'b1, 0);
      chk("bit9_count", bus.count, 4'd1);
      chk("bit9_E_Data", bus.E_Data, 8'h57);
      send_bit(1'b0, 1);
      chk("cntrst_count", bus.count, 4'd1);
      chk("cntrst_E_Data", bus.E_Data, 8'hAE);
      end_frame();

      send_bit(1'b1, 0);
      s0 = strobes;
      send_bit(1'b0, 2);
      chk("reset_E_Data", bus.E_Data, 8'h00);
      chk("reset_count", bus.count, 4'd0);
      chk("reset_no_strobe", strobes, s0);
      send_bit(1'b1, 0);
      chk("after_reset_count", bus.count, 4'd1);
      chk("after_reset_E_Data", bus.E_Data, 8'h01);
      end_frame();

      e0 = edges;
      s0 = strobes;
      @(negedge clk);
      bus.d_line = 1'b1;
      @(negedge clk);
      bus.d_line = 1'b0;
      repeat (30) @(negedge clk);
`ifdef ERX_GLITCH_FILTER_EN
      chk("glitch_edges", edges - e0, 0);
      chk("glitch_strobes", strobes - s0, 0);
`else
      chk("glitch_edges", edges - e0, 2);
      chk("glitch_strobes", strobes - s0, 1);
      bits_q.push_back(1'b1);
      nbits++;
      exp_strobes++;
`endif
      chk("glitch_E_Data", bus.E_Data, exp_e());
      chk("glitch_count", bus.count, exp_count());
      chk("glitch_Idle", bus.Idle, 1'b1);

      for (int f = 0; f < 5; f++) begin
         len = $urandom_range(6, 12);
         for (int i = 0; i < len; i++) begin
            r  = $urandom_range(0, 9);
            md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            send_bit((i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), md);
         end
         chk("rand_Idle_busy", bus.Idle, 1'b0);
         end_frame();
      end

      for (int i = 7; i >= 3; i--) send_bit(ab[i], 0);
      @(negedge clk);
      n_rst = 1'b0;
      bus.d_line = 1'b0;
      #1;
      chk("nrst_Idle", bus.Idle, 1'b1);
      chk("nrst_E_Data", bus.E_Data, 8'h00);
      chk("nrst_count", bus.count, 4'd0);
      chk("nrst_d_edge", bus.d_edge, 1'b0);
      chk("nrst_strobe", bus.bit_strobe, 1'b0);
      bits_q.delete();
      nbits = 0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 7; i >= 0; i--) send_bit(ab[i], 0);
      chk("post_nrst_E_Data", bus.E_Data, 8'hAB);
      chk("post_nrst_count", bus.count, 4'd8);
      end_frame();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
